// File: rtl/branch_cond_unit.sv
// Branch-condition unit: holds ALU status flags and a saturating hardware loop
// counter, and returns a registered taken/not-taken decision one cycle after each request.
// Optional V flag and signed conditions are compiled in with BRANCH_OVERFLOW_EN.
module branch_cond_unit #(
   parameter int WIDTH  = 16,
   parameter int LOOP_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_flag_we,
   input  logic [0:WIDTH-1]  i_result,
   input  logic              i_carry,
   input  logic              i_ovf,
   input  logic              i_req,
   input  logic [3:0]        i_cond,
   input  logic              i_loop_ld,
   input  logic [LOOP_W-1:0] i_loop_val,
   output logic              o_valid,
   output logic              o_taken,
   output logic [0:3]        o_flags,
   output logic              o_loop_zero
);

   localparam logic [3:0] COND_NEVER  = 4'd0;
   localparam logic [3:0] COND_ALWAYS = 4'd1;
   localparam logic [3:0] COND_Z      = 4'd2;
   localparam logic [3:0] COND_NZ     = 4'd3;
   localparam logic [3:0] COND_C      = 4'd4;
   localparam logic [3:0] COND_NC     = 4'd5;
   localparam logic [3:0] COND_S      = 4'd6;
   localparam logic [3:0] COND_NS     = 4'd7;
   localparam logic [3:0] COND_V      = 4'd8;
   localparam logic [3:0] COND_NV     = 4'd9;
   localparam logic [3:0] COND_HI     = 4'd10;
   localparam logic [3:0] COND_LS     = 4'd11;
   localparam logic [3:0] COND_GE     = 4'd12;
   localparam logic [3:0] COND_LT     = 4'd13;
   localparam logic [3:0] COND_GT     = 4'd14;
   localparam logic [3:0] COND_LOOP   = 4'd15;

   logic              s_q, s_d;
   logic              z_q, z_d;
   logic              c_q, c_d;
   logic              v_q;
   logic [LOOP_W-1:0] cnt_q, cnt_d;
   logic              valid_q, valid_d;
   logic              taken_q, taken_d;

   // Flag values seen by a request this cycle (bypassed from the ALU when written now)
   logic              s_eff, z_eff, c_eff, v_eff;
   logic [LOOP_W-1:0] cnt_eff;
   logic [LOOP_W-1:0] cnt_dec;
   logic              loop_req;
   logic              loop_take;
   logic              cond_hit;

   always_comb begin
      s_eff = s_q;
      z_eff = z_q;
      c_eff = c_q;
      v_eff = v_q;
      if (i_flag_we) begin
         s_eff = i_result[0];
         z_eff = (i_result == '0);
         c_eff = i_carry;
`ifdef BRANCH_OVERFLOW_EN
         v_eff = i_ovf;
`endif
      end
   end

   always_comb begin
      s_d = s_q;
      z_d = z_q;
      c_d = c_q;
      if (i_flag_we) begin
         s_d = s_eff;
         z_d = z_eff;
         c_d = c_eff;
      end
   end

   // A load in the same cycle as a LOOP request is applied before the decrement
   always_comb begin
      loop_req  = i_req && (i_cond == COND_LOOP);
      cnt_eff   = i_loop_ld ? i_loop_val : cnt_q;
      cnt_dec   = (cnt_eff != '0) ? (cnt_eff - LOOP_W'(1)) : '0;
      loop_take = (cnt_eff != '0) && (cnt_dec != '0);
      cnt_d     = cnt_q;
      if (loop_req) begin
         cnt_d = cnt_dec;
      end else if (i_loop_ld) begin
         cnt_d = i_loop_val;
      end
   end

   always_comb begin
      cond_hit = 1'b0;
      case (i_cond)
         COND_NEVER:  cond_hit = 1'b0;
         COND_ALWAYS: cond_hit = 1'b1;
         COND_Z:      cond_hit = z_eff;
         COND_NZ:     cond_hit = !z_eff;
         COND_C:      cond_hit = c_eff;
         COND_NC:     cond_hit = !c_eff;
         COND_S:      cond_hit = s_eff;
         COND_NS:     cond_hit = !s_eff;
`ifdef BRANCH_OVERFLOW_EN
         COND_V:      cond_hit = v_eff;
         COND_NV:     cond_hit = !v_eff;
         COND_GE:     cond_hit = (s_eff == v_eff);
         COND_LT:     cond_hit = (s_eff != v_eff);
         COND_GT:     cond_hit = !z_eff && (s_eff == v_eff);
`else
         COND_V, COND_NV, COND_GE, COND_LT, COND_GT: cond_hit = 1'b0;
`endif
         COND_HI:     cond_hit = c_eff && !z_eff;
         COND_LS:     cond_hit = !c_eff || z_eff;
         COND_LOOP:   cond_hit = loop_take;
         default:     cond_hit = 1'b0;
      endcase
   end

   always_comb begin
      valid_d = i_req;
      taken_d = i_req && cond_hit;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         s_q     <= 1'b0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         taken_q <= 1'b0;
      end else begin
         s_q     <= s_d;
         z_q     <= z_d;
         c_q     <= c_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         taken_q <= taken_d;
      end
   end

`ifdef BRANCH_OVERFLOW_EN
   logic v_d;

   always_comb begin
      v_d = v_q;
      if (i_flag_we) begin
         v_d = v_eff;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v_q <= 1'b0;
      end else begin
         v_q <= v_d;
      end
   end
`else
   // No V register in this build; the overflow input is deliberately left unconnected
   logic unused_ovf;

   assign v_q        = 1'b0;
   assign unused_ovf = i_ovf;
`endif

   assign o_valid     = valid_q;
   assign o_taken     = taken_q;
   assign o_flags     = {s_q, z_q, c_q, v_q};
   assign o_loop_zero = (cnt_q == '0);

endmodule

// File: tb/tb_branch_cond_unit.sv
// Bench for branch_cond_unit: directed scenarios plus randomized traffic checked
// against a behavioural flag/counter model.
module tb_branch_cond_unit;

   localparam int WIDTH  = 16;
   localparam int LOOP_W = 8;

   logic              clk;
   logic              rst_n;
   logic              flag_we;
   logic [0:WIDTH-1]  result;
   logic              carry;
   logic              ovf;
   logic              req;
   logic [3:0]        cond;
   logic              loop_ld;
   logic [LOOP_W-1:0] loop_val;
   logic              o_valid;
   logic              o_taken;
   logic [0:3]        o_flags;
   logic              o_loop_zero;

   int n_vec;
   int n_err;

   // behavioural model state
   bit m_s, m_z, m_c, m_v;
   int m_cnt;
   bit e_valid, e_taken;

   branch_cond_unit #(.WIDTH(WIDTH), .LOOP_W(LOOP_W)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_flag_we   (flag_we),
      .i_result    (result),
      .i_carry     (carry),
      .i_ovf       (ovf),
      .i_req       (req),
      .i_cond      (cond),
      .i_loop_ld   (loop_ld),
      .i_loop_val  (loop_val),
      .o_valid     (o_valid),
      .o_taken     (o_taken),
      .o_flags     (o_flags),
      .o_loop_zero (o_loop_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef BRANCH_OVERFLOW_EN
   localparam bit HAS_V = 1'b1;
`else
   localparam bit HAS_V = 1'b0;
`endif

   function automatic bit model_cond(int code, bit s, bit z, bit c, bit v, int cnt);
      case (code)
         0:  return 1'b0;
         1:  return 1'b1;
         2:  return z;
         3:  return !z;
         4:  return c;
         5:  return !c;
         6:  return s;
         7:  return !s;
         8:  return HAS_V && v;
         9:  return HAS_V && !v;
         10: return c && !z;
         11: return !c || z;
         12: return HAS_V && (s == v);
         13: return HAS_V && (s != v);
         14: return HAS_V && !z && (s == v);
         default: return cnt >= 2;
      endcase
   endfunction

   task automatic drive(bit we, logic [0:WIDTH-1] res, bit cy, bit ov, bit rq,
                        int cd, bit ld, int val);
      flag_we  = we;
      result   = res;
      carry    = cy;
      ovf      = ov;
      req      = rq;
      cond     = 4'(cd);
      loop_ld  = ld;
      loop_val = LOOP_W'(val);
   endtask

   task automatic idle();
      drive(0, '0, 0, 0, 0, 0, 0, 0);
   endtask

   // Predict the cycle's outcome from the current inputs, then advance one clock.
   task automatic tick();
      bit s, z, c, v;
      int cnt;
      s = m_s; z = m_z; c = m_c; v = m_v;
      if (flag_we) begin
         s = result[0];
         z = (result == 0);
         c = carry;
         v = HAS_V ? ovf : 1'b0;
      end
      cnt     = loop_ld ? int'(loop_val) : m_cnt;
      e_valid = req;
      e_taken = req && model_cond(int'(cond), s, z, c, v, cnt);
      if (req && cond == 4'd15) m_cnt = (cnt > 0) ? cnt - 1 : 0;
      else if (loop_ld)         m_cnt = int'(loop_val);
      m_s = s; m_z = z; m_c = c; m_v = v;
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_s = 0; m_z = 0; m_c = 0; m_v = 0; m_cnt = 0;
      e_valid = 0; e_taken = 0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (o_valid !== 1'b0 || o_taken !== 1'b0) begin
         n_err++;
         $display("FAIL reset_out: valid=%b taken=%b required 0 0", o_valid, o_taken);
      end
      n_vec++;
      if (o_flags !== 4'b0000 || o_loop_zero !== 1'b1) begin
         n_err++;
         $display("FAIL reset_state: flags=%b loop_zero=%b required 0000 1", o_flags, o_loop_zero);
      end
      rst_n = 1'b1;
      drive(0, '0, 0, 0, 1, 1, 0, 0);
      tick();
      n_vec++;
      if (o_valid !== 1'b1 || o_taken !== 1'b1) begin
         n_err++;
         $display("FAIL first_always: valid=%b taken=%b required 1 1", o_valid, o_taken);
      end
      idle();
      tick();
      n_vec++;
      if (o_valid !== 1'b0 || o_taken !== 1'b0) begin
         n_err++;
         $display("FAIL no_req_idle: valid=%b taken=%b required 0 0", o_valid, o_taken);
      end
   endtask

   task automatic test_bypass();
      drive(1, 16'h0000, 1, 0, 1, 2, 0, 0);
      tick();
      n_vec++;
      if (o_valid !== 1'b1 || o_taken !== 1'b1) begin
         n_err++;
         $display("FAIL bypass_z: valid=%b taken=%b required 1 1", o_valid, o_taken);
      end
      n_vec++;
      if (o_flags !== 4'b0110) begin
         n_err++;
         $display("FAIL flags_after_we: flags=%b required 0110", o_flags);
      end
      drive(0, 16'hFFFF, 0, 0, 1, 10, 0, 0);
      tick();
      n_vec++;
      if (o_valid !== 1'b1 || o_taken !== 1'b0) begin
         n_err++;
         $display("FAIL hi_with_z: valid=%b taken=%b required 1 0", o_valid, o_taken);
      end
      n_vec++;
      if (o_flags !== 4'b0110) begin
         n_err++;
         $display("FAIL flags_hold: flags=%b required 0110", o_flags);
      end
   endtask

   task automatic test_loop();
      bit exp_t[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
      drive(0, '0, 0, 0, 0, 0, 1, 3);
      tick();
      n_vec++;
      if (o_loop_zero !== 1'b0) begin
         n_err++;
         $display("FAIL loop_load3: loop_zero=%b required 0", o_loop_zero);
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, '0, 0, 0, 1, 15, 0, 0);
         tick();
         n_vec++;
         if (o_valid !== 1'b1 || o_taken !== exp_t[i]) begin
            n_err++;
            $display("FAIL loop_iter%0d: valid=%b taken=%b required 1 %b", i, o_valid, o_taken, exp_t[i]);
         end
         n_vec++;
         if (o_loop_zero !== (i >= 2)) begin
            n_err++;
            $display("FAIL loop_zero%0d: loop_zero=%b required %b", i, o_loop_zero, (i >= 2));
         end
      end
      idle();
   endtask

   task automatic test_loop_load();
      int vals[2] = '{1, 0};
      foreach (vals[i]) begin
         drive(0, '0, 0, 0, 1, 15, 1, vals[i]);
         tick();
         n_vec++;
         if (o_valid !== 1'b1 || o_taken !== 1'b0 || o_loop_zero !== 1'b1) begin
            n_err++;
            $display("FAIL ld_loop_val%0d: valid=%b taken=%b loop_zero=%b required 1 0 1",
                     vals[i], o_valid, o_taken, o_loop_zero);
         end
      end
      // A load followed by non-LOOP requests must leave the counter alone
      drive(0, '0, 0, 0, 0, 0, 1, 2);
      tick();
      drive(0, '0, 0, 0, 1, 1, 0, 0);
      tick();
      drive(0, '0, 0, 0, 1, 15, 0, 0);
      tick();
      n_vec++;
      if (o_taken !== 1'b1 || o_loop_zero !== 1'b0) begin
         n_err++;
         $display("FAIL cnt_untouched: taken=%b loop_zero=%b required 1 0", o_taken, o_loop_zero);
      end
      idle();
   endtask

   task automatic test_overflow();
      drive(1, 16'h8000, 0, 1, 0, 0, 0, 0);
      tick();
      n_vec++;
      if (o_flags !== {1'b1, 1'b0, 1'b0, HAS_V}) begin
         n_err++;
         $display("FAIL ovf_flags: flags=%b required %b", o_flags, {1'b1, 1'b0, 1'b0, HAS_V});
      end
      drive(0, '0, 0, 0, 1, 12, 0, 0);
      tick();
      n_vec++;
      if (o_valid !== 1'b1 || o_taken !== HAS_V) begin
         n_err++;
         $display("FAIL ge_cond: valid=%b taken=%b required 1 %b", o_valid, o_taken, HAS_V);
      end
      drive(0, '0, 0, 0, 1, 13, 0, 0);
      tick();
      n_vec++;
      if (o_valid !== 1'b1 || o_taken !== 1'b0) begin
         n_err++;
         $display("FAIL lt_cond: valid=%b taken=%b required 1 0", o_valid, o_taken);
      end
      idle();
   endtask

   task automatic test_async_reset();
      drive(1, 16'h8001, 1, 1, 0, 0, 1, 5);
      tick();
      drive(0, '0, 0, 0, 1, 15, 0, 0);
      #3;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_vec++;
      if (o_flags !== 4'b0000 || o_loop_zero !== 1'b1 || o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: flags=%b loop_zero=%b valid=%b required 0000 1 0",
                  o_flags, o_loop_zero, o_valid);
      end
      @(posedge clk);
      #1;
      idle();
      rst_n = 1'b1;
      tick();
      n_vec++;
      if (o_valid !== 1'b0 || o_taken !== 1'b0 || o_loop_zero !== 1'b1) begin
         n_err++;
         $display("FAIL post_release: valid=%b taken=%b loop_zero=%b required 0 0 1",
                  o_valid, o_taken, o_loop_zero);
      end
   endtask

   task automatic test_random();
      logic [0:WIDTH-1] res;
      for (int i = 0; i < 400; i++) begin
         res = ($urandom_range(0, 3) == 0) ? '0 : WIDTH'($urandom);
         drive($urandom_range(0, 2) == 0, res, 1'($urandom), 1'($urandom),
               $urandom_range(0, 3) != 0,
               ($urandom_range(0, 2) == 0) ? 15 : int'($urandom_range(0, 15)),
               $urandom_range(0, 5) == 0, int'($urandom_range(0, 4)));
         tick();
         n_vec++;
         if (o_valid !== e_valid || o_taken !== e_taken) begin
            n_err++;
            $display("FAIL rand_decision[%0d]: valid=%b taken=%b required %b %b",
                     i, o_valid, o_taken, e_valid, e_taken);
         end
         n_vec++;
         if (o_flags !== {m_s, m_z, m_c, m_v} || o_loop_zero !== (m_cnt == 0)) begin
            n_err++;
            $display("FAIL rand_state[%0d]: flags=%b loop_zero=%b required %b %b",
                     i, o_flags, o_loop_zero, {m_s, m_z, m_c, m_v}, (m_cnt == 0));
         end
      end
      idle();
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_bypass();
      test_loop();
      test_loop_load();
      test_overflow();
      test_async_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_cond_unit.md
# branch_cond_unit

Parametrised branch-condition unit for the CPU's jump path. It holds the architectural status flags (S, Z, C and, optionally, V) captured from the ALU. It evaluates one of 16 condition codes against those flags, or against a hardware loop counter, and returns a registered taken/not-taken decision one cycle after each request. The fetch/PC logic consumes that decision.

## Interface
- WIDTH, 16: ALU result width; bit 0 is the MSB (sign), bit WIDTH-1 is the LSB.
- LOOP_W, 8: loop counter width.

- i_clk  in  1  sole clock; all state updates on its rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_flag_we  in  1  capture flags from i_result/i_carry/i_ovf this cycle.
- i_result  in  WIDTH  ALU result; source of S (bit 0) and Z (all bits zero).
- i_carry  in  1  ALU carry out; 1 = no borrow on subtract.
- i_ovf  in  1  ALU signed overflow; ignored unless the overflow feature is compiled in.
- i_req  in  1  evaluate condition i_cond this cycle.
- i_cond  in  4  condition code, sampled when i_req=1.
- i_loop_ld  in  1  load loop counter from i_loop_val.
- i_loop_val  in  LOOP_W  loop counter load value.
- o_valid  out  1  registered; high for exactly one cycle per accepted request.
- o_taken  out  1  registered decision; 0 whenever o_valid=0.
- o_flags  out  4  {S,Z,C,V}, the current flag register.
- o_loop_zero  out  1  loop counter equals 0.

## Operation
- Flags: on i_flag_we, S<=i_result[0]; Z<=(i_result==0); C<=i_carry; V<=i_ovf (feature on). Flags hold when i_flag_we=0.
- Bypass: if i_req and i_flag_we are both high in one cycle, the condition uses the incoming flag values, not the registered ones.
- Condition codes:
  - 0 never
  - 1 always
  - 2 Z, 3 !Z
  - 4 C, 5 !C
  - 6 S, 7 !S
  - 8 V, 9 !V
  - 10 HI = C&!Z, 11 LS = !C|Z
  - 12 GE = S==V, 13 LT = S!=V, 14 GT = !Z&(S==V)
  - 15 LOOP
- LOOP (i_req, i_cond=15):
  - Counter value cnt != 0: counter <= cnt-1; taken iff cnt-1 != 0.
  - cnt == 0: counter stays 0 (saturates, no wrap); not taken.
- Load priority: i_loop_ld in the same cycle as a LOOP request makes cnt = i_loop_val. The result is counter <= i_loop_val-1 (or 0 if i_loop_val=0), evaluated as above.
- i_loop_ld without a LOOP request: counter <= i_loop_val.
- Requests with codes 0–14 never alter the counter.
- No back-pressure: a request is accepted every cycle i_req=1; back-to-back requests give back-to-back o_valid pulses.

## Timing
- Latency: request in cycle N gives o_valid/o_taken in cycle N+1.
- Flags written in cycle N are visible on o_flags in N+1 and to requests from N onward (bypass).
- Counter written in cycle N: o_loop_zero updates in N+1.
- Reset (asynchronous, any time, including mid-loop):
  - o_valid=0, o_taken=0, flags=0000, counter=0, o_loop_zero=1.
  - A request in flight during reset is dropped; no o_valid follows reset release.
- Without a request in cycle N, o_valid=0 and o_taken=0 in N+1.

## Configuration
- BRANCH_OVERFLOW_EN defined:
  - V flag register present; codes 8, 9 and 12–14 behave as listed.
- BRANCH_OVERFLOW_EN undefined:
  - No V register; i_ovf unused; o_flags[3] tied 0.
  - Codes 8, 9, 12, 13 and 14 evaluate not taken, still with an o_valid pulse.
  - All other codes unchanged.

## Test plan
- Reset then req cond=1 -> next cycle o_valid=1, o_taken=1; following cycle o_valid=0, o_taken=0; o_flags=0000, o_loop_zero=1 after reset.
- flag_we with result=0x0000, carry=1, plus req cond=2 in the same cycle -> o_taken=1 (bypass); next cycle o_flags={0,1,1,0}; req cond=10 -> o_taken=0.
- loop_ld val=3, then three LOOP reqs back-to-back -> o_taken 1,1,0; o_loop_zero=1 after the third; a fourth LOOP req -> taken=0, counter stays 0.
- loop_ld val=1 together with a LOOP req -> o_taken=0, counter=0; loop_ld val=0 with a LOOP req -> o_taken=0, counter=0.
- (BRANCH_OVERFLOW_EN) flag_we result=0x8000, ovf=1 -> req 12 (GE) taken=1, req 13 (LT) taken=0; without the macro -> both 0, o_flags[3]=0.
- Assert i_rst_n low while a LOOP counter=5 and a req are pending -> o_valid stays 0, counter=0, flags=0000 immediately (asynchronous), no pulse after release.
